// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with an optional second (skid) entry, flush, hazard stall,
// and a saturating counter of cycles in which a valid output was blocked.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter bit                SKID       = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o,
    output logic [15:0]       stall_cnt_o
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [15:0]       stall_cnt_q;
    logic              out_valid;
    logic              accept;
    logic              fire;
    logic              blocked;

    assign out_valid = (state_q != ST_EMPTY);
    assign fire      = out_valid & out_ready_i & ~stall_i;

    // NOTE: without a skid entry, ready must look through to the downstream handshake,
    // which puts out_ready_i/stall_i on a combinational path to in_ready_o.
    assign in_ready_o = SKID ? (state_q != ST_SKID)
                             : (~out_valid | (out_ready_i & ~stall_i));
    assign accept     = in_valid_i & in_ready_o;
    assign blocked    = out_valid & (stall_i | ~out_ready_i);

    // NOTE: sequential state uses non-blocking assignments only; the payload registers
    // are reset as well because BUBBLE_VAL is their defined idle content.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data_i;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (fire && accept) begin
                        main_q <= in_data_i;
                    end else if (fire) begin
                        state_q <= ST_EMPTY;
                    end else if (accept && SKID) begin
                        skid_q  <= in_data_i;
                        state_q <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (fire) begin
                        main_q  <= skid_q;
                        state_q <= ST_FULL;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= 16'd0;
        end else if (blocked && !flush_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign out_valid_o = out_valid;
    assign out_data_o  = out_valid ? main_q : BUBBLE_VAL;
    assign occ_o       = state_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one instance with the skid entry, one without.
module tb_pipe_stage_reg;

    localparam logic [63:0] BUB  = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [63:0] NBUB = 64'h0;

    logic        clk_i = 1'b0;
    logic        rst_n_i, flush_i, stall_i, in_valid_i, out_ready_i;
    logic        in_ready_o, out_valid_o;
    logic [63:0] in_data_i, out_data_o;
    logic [1:0]  occ_o;
    logic [15:0] stall_cnt_o;

    logic        n_rst_n, n_flush, n_stall, n_in_valid, n_out_ready;
    logic        n_in_ready, n_out_valid;
    logic [63:0] n_in_data, n_out_data;
    logic [1:0]  n_occ;
    logic [15:0] n_stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_reg #(.DATA_W(64), .BUBBLE_VAL(BUB), .SKID(1'b1)) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .stall_i(stall_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .occ_o(occ_o), .stall_cnt_o(stall_cnt_o)
    );

    pipe_stage_reg #(.DATA_W(64), .BUBBLE_VAL(NBUB), .SKID(1'b0)) u_nsk (
        .clk_i(clk_i), .rst_n_i(n_rst_n), .flush_i(n_flush), .stall_i(n_stall),
        .in_valid_i(n_in_valid), .in_ready_o(n_in_ready), .in_data_i(n_in_data),
        .out_valid_o(n_out_valid), .out_ready_i(n_out_ready), .out_data_o(n_out_data),
        .occ_o(n_occ), .stall_cnt_o(n_stall_cnt)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; flush_i = 1'b1; stall_i = 1'b1;
        in_valid_i = 1'b1; out_ready_i = 1'b1; in_data_i = 64'h77;
        step(); step();
        vectors++;
        if (occ_o !== 2'd0) begin miscompares++; $display("FAIL reset_occ: got %0d expected 0", occ_o); end
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
        vectors++;
        if (out_data_o !== BUB) begin miscompares++; $display("FAIL reset_data: got %h expected %h", out_data_o, BUB); end
        vectors++;
        if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", in_ready_o); end
        vectors++;
        if (stall_cnt_o !== 16'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt_o); end
        rst_n_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0; in_valid_i = 1'b0;
    endtask

    task automatic test_stream();
        out_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid_i = 1'b1; in_data_i = 64'(i);
            step();
            vectors++;
            if (out_valid_o !== 1'b1 || out_data_o !== 64'(i)) begin
                miscompares++; $display("FAIL stream_data: got v=%b %h expected v=1 %h", out_valid_o, out_data_o, 64'(i));
            end
            vectors++;
            if (occ_o !== 2'd1) begin miscompares++; $display("FAIL stream_occ: got %0d expected 1", occ_o); end
        end
        in_valid_i = 1'b0;
        step();
        vectors++;
        if (out_valid_o !== 1'b0 || out_data_o !== BUB) begin
            miscompares++; $display("FAIL stream_drain: got v=%b %h expected v=0 %h", out_valid_o, out_data_o, BUB);
        end
        vectors++;
        if (stall_cnt_o !== 16'd0) begin miscompares++; $display("FAIL stream_cnt: got %0d expected 0", stall_cnt_o); end
    endtask

    task automatic test_stall_skid();
        out_ready_i = 1'b1; stall_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 64'hA;
        step();
        stall_i = 1'b1; in_data_i = 64'hB;
        step();
        vectors++;
        if (occ_o !== 2'd2 || in_ready_o !== 1'b0) begin
            miscompares++; $display("FAIL skid_fill: got occ=%0d rdy=%b expected occ=2 rdy=0", occ_o, in_ready_o);
        end
        in_data_i = 64'hC;  // must be refused while the skid entry is occupied
        step(); step();
        vectors++;
        if (out_data_o !== 64'hA || out_valid_o !== 1'b1) begin
            miscompares++; $display("FAIL stall_hold: got v=%b %h expected v=1 a", out_valid_o, out_data_o);
        end
        vectors++;
        if (stall_cnt_o !== 16'd3) begin miscompares++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt_o); end
        vectors++;
        if (occ_o !== 2'd2) begin miscompares++; $display("FAIL stall_occ: got %0d expected 2", occ_o); end
        stall_i = 1'b0; in_valid_i = 1'b0;
        step();
        vectors++;
        if (out_data_o !== 64'hB || occ_o !== 2'd1) begin
            miscompares++; $display("FAIL release_b: got %h occ=%0d expected b occ=1", out_data_o, occ_o);
        end
        step();
        vectors++;
        if (out_valid_o !== 1'b0 || occ_o !== 2'd0) begin
            miscompares++; $display("FAIL release_empty: got v=%b occ=%0d expected v=0 occ=0", out_valid_o, occ_o);
        end
        vectors++;
        if (stall_cnt_o !== 16'd3) begin miscompares++; $display("FAIL release_cnt: got %0d expected 3", stall_cnt_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 64'h11;
        step();
        in_data_i = 64'h22;
        step();
        vectors++;
        if (occ_o !== 2'd2) begin miscompares++; $display("FAIL flush_pre_occ: got %0d expected 2", occ_o); end
        flush_i = 1'b1; in_data_i = 64'h33;
        step();
        vectors++;
        if (occ_o !== 2'd0 || out_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL flush_state: got occ=%0d v=%b expected occ=0 v=0", occ_o, out_valid_o);
        end
        vectors++;
        if (out_data_o !== BUB) begin miscompares++; $display("FAIL flush_data: got %h expected %h", out_data_o, BUB); end
        vectors++;
        if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b expected 1", in_ready_o); end
        vectors++;
        if (stall_cnt_o !== 16'd4) begin miscompares++; $display("FAIL flush_cnt: got %0d expected 4", stall_cnt_o); end
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        step();
        vectors++;
        if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_discard: got v=%b %h expected v=0", out_valid_o, out_data_o); end
    endtask

    task automatic test_reset_in_skid();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 64'h44;
        step();
        in_data_i = 64'h45;
        step();
        vectors++;
        if (occ_o !== 2'd2) begin miscompares++; $display("FAIL rskid_pre_occ: got %0d expected 2", occ_o); end
        rst_n_i = 1'b0; out_ready_i = 1'b1; stall_i = 1'b1; in_data_i = 64'h46;
        step();
        vectors++;
        if (occ_o !== 2'd0 || out_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL rskid_state: got occ=%0d v=%b expected occ=0 v=0", occ_o, out_valid_o);
        end
        vectors++;
        if (stall_cnt_o !== 16'd0) begin miscompares++; $display("FAIL rskid_cnt: got %0d expected 0", stall_cnt_o); end
        vectors++;
        if (out_data_o !== BUB || in_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL rskid_out: got %h rdy=%b expected %h rdy=1", out_data_o, in_ready_o, BUB);
        end
        rst_n_i = 1'b1; stall_i = 1'b0; in_valid_i = 1'b0;
    endtask

    task automatic test_cnt_saturate();
        out_ready_i = 1'b1; in_valid_i = 1'b1; in_data_i = 64'h55;
        step();
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        step();
        vectors++;
        if (stall_cnt_o !== 16'd1) begin miscompares++; $display("FAIL sat_first: got %0d expected 1", stall_cnt_o); end
        repeat (65533) step();
        vectors++;
        if (stall_cnt_o !== 16'hFFFE) begin miscompares++; $display("FAIL sat_edge: got %h expected fffe", stall_cnt_o); end
        step();
        vectors++;
        if (stall_cnt_o !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach: got %h expected ffff", stall_cnt_o); end
        repeat (4465) step();
        vectors++;
        if (stall_cnt_o !== 16'hFFFF) begin miscompares++; $display("FAIL sat_nowrap: got %h expected ffff", stall_cnt_o); end
        vectors++;
        if (out_data_o !== 64'h55 || occ_o !== 2'd1) begin
            miscompares++; $display("FAIL sat_hold: got %h occ=%0d expected 55 occ=1", out_data_o, occ_o);
        end
        out_ready_i = 1'b1;
        step();
    endtask

    task automatic test_noskid();
        n_rst_n = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0;
        step();
        vectors++;
        if (n_occ !== 2'd0 || n_out_valid !== 1'b0 || n_in_ready !== 1'b1) begin
            miscompares++; $display("FAIL nsk_reset: got occ=%0d v=%b rdy=%b expected 0 0 1", n_occ, n_out_valid, n_in_ready);
        end
        n_rst_n = 1'b1; n_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_in_valid = 1'b1; n_in_data = 64'h10 + 64'(i);
            #1;
            vectors++;
            if (n_in_ready !== 1'b1) begin miscompares++; $display("FAIL nsk_ready_pass: got %b expected 1", n_in_ready); end
            step();
            vectors++;
            if (n_out_data !== 64'h10 + 64'(i) || n_occ !== 2'd1) begin
                miscompares++; $display("FAIL nsk_stream: got %h occ=%0d expected %h occ=1", n_out_data, n_occ, 64'h10 + 64'(i));
            end
        end
        n_out_ready = 1'b0; n_in_data = 64'h20;
        #1;
        vectors++;
        if (n_in_ready !== 1'b0) begin miscompares++; $display("FAIL nsk_ready_block: got %b expected 0", n_in_ready); end
        step();
        vectors++;
        if (n_out_data !== 64'h14 || n_occ !== 2'd1) begin
            miscompares++; $display("FAIL nsk_hold: got %h occ=%0d expected 14 occ=1", n_out_data, n_occ);
        end
        n_out_ready = 1'b1; n_stall = 1'b1;
        #1;
        vectors++;
        if (n_in_ready !== 1'b0) begin miscompares++; $display("FAIL nsk_ready_stall: got %b expected 0", n_in_ready); end
        n_stall = 1'b0; n_in_valid = 1'b0;
        step();
        vectors++;
        if (n_out_valid !== 1'b0 || n_out_data !== NBUB) begin
            miscompares++; $display("FAIL nsk_drain: got v=%b %h expected v=0 0", n_out_valid, n_out_data);
        end
    endtask

    initial begin
        n_rst_n = 1'b0; n_flush = 1'b0; n_stall = 1'b0;
        n_in_valid = 1'b0; n_out_ready = 1'b0; n_in_data = '0;
        test_reset();
        test_stream();
        test_stall_skid();
        test_flush();
        test_reset_in_skid();
        test_cnt_saturate();
        test_noskid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
